dcpu16_run_ctrl: RTL
====================

DCPU16_RUN_CTRL -- requirements
Module: dcpu16_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the cycle, instruction and watchdog counters.
REQ-002 SHALL have parameter STEP_W, default 16, width of the N-step count.
REQ-003 SHALL have parameter SUCCESS_CODE, default 16'h3FF0, the illegal instruction treated as a pass.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1: begin a run from IDLE, or continue from PAUSE.
REQ-007 SHALL have port mode, input, 2: 0 free-run, 1 single-step, 2 N-step, 3 treated as 1; sampled only on an accepted start.
REQ-008 SHALL have port step_count, input, STEP_W: instruction budget for mode 2; sampled with mode.
REQ-009 SHALL have port watchdog_limit, input, CNT_W: RUN-cycle limit, 0 = disabled; sampled with mode.
REQ-010 SHALL have port halt_req, input, 1: external stop request.
REQ-011 SHALL have port step_req, output, 1: request to the core to execute one instruction.
REQ-012 SHALL have port step_ack, input, 1: core finished the requested instruction.
REQ-013 SHALL have ports instr (input, 16) and illegal (input, 1): executed instruction word and illegal-opcode flag, both valid only when step_ack=1.
REQ-014 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and status (output, 3).
REQ-015 SHALL have ports fail_instr (output, 16), instr_count (output, CNT_W) and cycle_count (output, CNT_W).

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSE and DONE; busy=1 in RUN and PAUSE.
REQ-017 SHALL define status codes: 0 none, 1 success, 2 illegal, 3 timeout, 4 budget-complete, 5 halted.
REQ-018 SHALL, on start in IDLE, clear instr_count, cycle_count, status and fail_instr, capture mode, step_count and watchdog_limit, and enter RUN next cycle.
REQ-019 SHALL, in mode 2 with step_count=0, go IDLE->DONE with status 4 and never assert step_req.
REQ-020 SHALL drive step_req=1 in every RUN cycle and 0 in all other states; step_req is held until step_ack is sampled high.
REQ-021 SHALL sample step_ack only in RUN, ignore it elsewhere, and not require a minimum latency (an ack in the first RUN cycle is legal).
REQ-022 SHALL increment instr_count by 1 on each sampled ack and increment cycle_count every RUN cycle; both saturate at all-ones and never wrap.
REQ-023 SHALL, on ack, decide in priority order: illegal && instr==SUCCESS_CODE -> status 1; illegal -> status 2 with fail_instr=instr; mode 2 and instr_count reaches step_count -> status 4; pending halt -> status 5; each of these enters DONE.
REQ-024 SHALL, on an ack with no termination, go to PAUSE in mode 1 and stay in RUN in modes 0 and 2, with step_req remaining high for the next instruction.
REQ-025 SHALL latch halt_req asserted in RUN into a sticky pending-halt that is honored only at the next ack (instruction boundary).
REQ-026 SHALL, on halt_req in PAUSE, enter DONE with status 5; when halt_req and start are both high in PAUSE, halt wins.
REQ-027 SHALL, on start in PAUSE, return to RUN; start in RUN or DONE is ignored.
REQ-028 SHALL, when watchdog_limit!=0 and the incremented cycle_count equals watchdog_limit in a cycle with no ack, enter DONE with status 3.
REQ-029 SHALL let an ack in the same cycle as watchdog expiry take precedence over the timeout.
REQ-030 SHALL pulse done for exactly the DONE cycle, then return to IDLE, holding status, fail_instr and the counters until the next accepted start.

Reset
REQ-031 SHALL, while reset=1, force state IDLE, step_req=0, busy=0, done=0, status=0, fail_instr=0, instr_count=0, cycle_count=0 and clear pending-halt.
REQ-032 SHALL let reset take priority over every input, including an ack in the same cycle; reset mid-run aborts the run without a done pulse.

Verification
REQ-033 SHALL cover free-run with ack 2 cycles after each req and the 4th instr=16'h3FF0 with illegal=1 -> done, status=1, instr_count=4.
REQ-034 SHALL cover free-run with the 2nd ack carrying illegal=1, instr=16'h7C01 -> status=2, fail_instr=16'h7C01, instr_count=2.
REQ-035 SHALL cover mode 2, step_count=5, ack every cycle -> status=4, instr_count=5, step_req low the cycle after the 5th ack.
REQ-036 SHALL cover mode 1 with 3 starts -> exactly one ack accepted per start with a PAUSE between; then halt_req+start in PAUSE -> status=5, instr_count=3.
REQ-037 SHALL cover watchdog_limit=8 with no ack -> done with status=3, cycle_count=8; with limit=8 and an ack exactly on cycle 8 -> no timeout.
REQ-038 SHALL cover reset asserted in RUN together with an ack -> all outputs at reset values next cycle, no done pulse, instr_count=0.

Source files
------------

// File: rtl/dcpu16_run_ctrl.sv
// ============================================================================
// Module   : dcpu16_run_ctrl
// Brief    : Run controller for a DCPU-16 core. It handles free-run, single-step
//            and N-step modes, a RUN-cycle watchdog and pass/fail detection.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcpu16_run_ctrl #(
    parameter int          CNT_W        = 32,
    parameter int          STEP_W       = 16,
    parameter logic [15:0] SUCCESS_CODE = 16'h3FF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step_count,
    input  logic [CNT_W-1:0]  watchdog_limit,
    input  logic              halt_req,
    output logic              step_req,
    input  logic              step_ack,
    input  logic [15:0]       instr,
    input  logic              illegal,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    output logic [15:0]       fail_instr,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] C_ST_NONE    = 3'd0;
    localparam logic [2:0] C_ST_SUCCESS = 3'd1;
    localparam logic [2:0] C_ST_ILLEGAL = 3'd2;
    localparam logic [2:0] C_ST_TIMEOUT = 3'd3;
    localparam logic [2:0] C_ST_BUDGET  = 3'd4;
    localparam logic [2:0] C_ST_HALTED  = 3'd5;

    localparam int CMP_W = (CNT_W > STEP_W) ? CNT_W : STEP_W;

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [STEP_W-1:0]  r_budget;
    logic [CNT_W-1:0]   r_wdog;
    logic               r_pend_halt;

    logic [CNT_W-1:0]   w_ic_inc;
    logic [CNT_W-1:0]   w_cc_inc;
    logic               w_budget_hit;
    logic               w_end;
    logic [2:0]         w_end_status;
    logic               w_pause;

    // Saturating increments: counters stick at all-ones rather than wrap.
    always_comb begin
        w_ic_inc = (instr_count == '1) ? instr_count : instr_count + CNT_W'(1);
        w_cc_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
        w_budget_hit = (CMP_W'(w_ic_inc) == CMP_W'(r_budget));
    end

    // Termination decision for a RUN cycle; an ack always outranks the watchdog.
    // Modes 1 and 3 share bit 0 set, which is the single-step behaviour.
    always_comb begin
        w_end        = 1'b0;
        w_end_status = C_ST_NONE;
        w_pause      = 1'b0;
        if (step_ack) begin
            if (illegal && (instr == SUCCESS_CODE)) begin
                w_end        = 1'b1;
                w_end_status = C_ST_SUCCESS;
            end else if (illegal) begin
                w_end        = 1'b1;
                w_end_status = C_ST_ILLEGAL;
            end else if ((r_mode == 2'd2) && w_budget_hit) begin
                w_end        = 1'b1;
                w_end_status = C_ST_BUDGET;
            end else if (r_pend_halt || halt_req) begin
                w_end        = 1'b1;
                w_end_status = C_ST_HALTED;
            end else if (r_mode[0]) begin
                w_pause      = 1'b1;
            end
        end else if ((r_wdog != '0) && (w_cc_inc == r_wdog)) begin
            w_end        = 1'b1;
            w_end_status = C_ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_budget    <= '0;
            r_wdog      <= '0;
            r_pend_halt <= 1'b0;
            step_req    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= C_ST_NONE;
            fail_instr  <= '0;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        instr_count <= '0;
                        cycle_count <= '0;
                        status      <= C_ST_NONE;
                        fail_instr  <= '0;
                        r_pend_halt <= 1'b0;
                        r_mode      <= mode;
                        r_budget    <= step_count;
                        r_wdog      <= watchdog_limit;
                        if ((mode == 2'd2) && (step_count == '0)) begin
                            r_state <= S_DONE;
                            status  <= C_ST_BUDGET;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            step_req <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cycle_count <= w_cc_inc;
                    if (step_ack) begin
                        instr_count <= w_ic_inc;
                    end
                    if (w_end) begin
                        r_state     <= S_DONE;
                        status      <= w_end_status;
                        done        <= 1'b1;
                        step_req    <= 1'b0;
                        busy        <= 1'b0;
                        r_pend_halt <= 1'b0;
                        if (w_end_status == C_ST_ILLEGAL) begin
                            fail_instr <= instr;
                        end
                    end else if (w_pause) begin
                        r_state  <= S_PAUSE;
                        step_req <= 1'b0;
                    end else if (halt_req) begin
                        r_pend_halt <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (halt_req) begin
                        r_state <= S_DONE;
                        status  <= C_ST_HALTED;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else if (start) begin
                        r_state  <= S_RUN;
                        step_req <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
